// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    // Sequencing states of the subtractor.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Width of the bit counter, which counts 0..width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fullsubtractor.sv
// Combinational 1-bit full subtractor: a - b - bin.
module fullsubtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles with one cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] ra_q, rb_q, diff_q;
    logic [CntW-1:0]  cnt_q;
    logic             br_q, sa_q, sb_q, bout_q, ovf_q;

    logic load, shift, last;
    logic cell_d, cell_bout;

    fullsubtractor u_cell (
        .a_i    (ra_q[0]),
        .b_i    (rb_q[0]),
        .bin_i  (br_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    assign last = (cnt_q == CntLast);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded controls and status outputs.
    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
        load   = (state_q == StIdle) && start_i;
        shift  = (state_q == StRun);
    end

    // Datapath: operand capture, serial shift, borrow flop, counter and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q   <= '0;
            rb_q   <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            ra_q   <= a_i;
            rb_q   <= b_i;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            sa_q   <= a_i[WIDTH-1];
            sb_q   <= b_i[WIDTH-1];
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (shift) begin
            ra_q   <= {1'b0, ra_q[WIDTH-1:1]};
            rb_q   <= {1'b0, rb_q[WIDTH-1:1]};
            diff_q <= {cell_d, diff_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + 1'b1;
            br_q   <= cell_bout;
            // Flags are settled on the last bit so they are already valid during done.
            if (last) begin
                bout_q <= cell_bout;
                ovf_q  <= (sa_q != sb_q) && (cell_d != sa_q);
            end
        end
    end

    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH 8 and 16) and its 1-bit cell.
module tb_serial_subtractor;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic d;
        logic bo;
    } cell_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0, busy8, done8, bout8, ovf8;
    logic [7:0]  a8 = '0, b8 = '0, diff8;
    logic        start16 = 1'b0, busy16, done16, bout16, ovf16;
    logic [15:0] a16 = '0, b16 = '0, diff16;
    logic        ca = 1'b0, cb = 1'b0, cbin = 1'b0, cd, cbo;

    int total = 0;
    int bad = 0;

    exp_t sb8[$];
    exp_t sb16[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .busy_o  (busy8),
        .done_o  (done8),
        .diff_o  (diff8),
        .bout_o  (bout8),
        .ovf_o   (ovf8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start16),
        .a_i     (a16),
        .b_i     (b16),
        .busy_o  (busy16),
        .done_o  (done16),
        .diff_o  (diff16),
        .bout_o  (bout16),
        .ovf_o   (ovf16)
    );

    fullsubtractor u_cell (
        .a_i    (ca),
        .b_i    (cb),
        .bin_i  (cbin),
        .d_o    (cd),
        .bout_o (cbo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected done", name);
    endtask

    // Reference built from signed/unsigned integer arithmetic rather than bit recurrences.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int w);
        exp_t   e;
        longint m, ua, ub, sa, sb, sd;
        m    = longint'(1) << w;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        e.diff = 16'((ua - ub + m) % m);
        e.bout = (ua < ub);
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        sd   = sa - sb;
        e.ovf  = (sd < -(m / 2)) || (sd >= m / 2);
        return e;
    endfunction

    // Scoreboard consumers: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                flag_fail("sb8_unexpected_done");
            end else begin
                e = sb8.pop_front();
                check("diff8", 32'(diff8), 32'(e.diff[7:0]));
                check("bout8", 32'(bout8), 32'(e.bout));
                check("ovf8", 32'(ovf8), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done16) begin
            if (sb16.size() == 0) begin
                flag_fail("sb16_unexpected_done");
            end else begin
                e = sb16.pop_front();
                check("diff16", 32'(diff16), 32'(e.diff));
                check("bout16", 32'(bout16), 32'(e.bout));
                check("ovf16", 32'(ovf16), 32'(e.ovf));
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int n;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) flag_fail("op8_timeout");
        @(negedge clk);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b;
        sb16.push_back(model(a, b, 16));
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done16) flag_fail("op16_timeout");
        @(negedge clk);
    endtask

    initial begin
        cell_t ct [8];
        vec_t  vt [7];
        exp_t  e;
        int    n, busy_cnt;

        ct[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ct[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ct[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ct[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ct[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ct[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ct[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ct[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        vt[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
        vt[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vt[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vt[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vt[5] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
        vt[6] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

        // Reset state.
        #2;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);

        // Exhaustive cell.
        for (int i = 0; i < 8; i++) begin
            ca = ct[i].a; cb = ct[i].b; cbin = ct[i].bin;
            #1;
            check($sformatf("cell_d_%0d", i), 32'(cd), 32'(ct[i].d));
            check($sformatf("cell_bo_%0d", i), 32'(cbo), 32'(ct[i].bo));
        end

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic op with latency and busy length.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
        sb8.push_back(model(8'h5A, 8'h23, 8));
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!done8 && n < 40) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            n++;
        end
        if (busy8) busy_cnt++;
        check("latency", 32'(n), 32'd9);
        check("busy_len", 32'(busy_cnt), 32'd9);
        @(negedge clk);
        check("done_pulse", 32'(done8), 32'd0);
        check("busy_fall", 32'(busy8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("hold_diff", 32'(diff8), 32'h37);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            e.diff = {8'h00, vt[i].diff};
            e.bout = vt[i].bout;
            e.ovf  = vt[i].ovf;
            op8(vt[i].a, vt[i].b, e);
        end
        check("hold_bout", 32'(bout8), 32'd0);
        check("hold_ovf", 32'(ovf8), 32'd1);

        // Start held, operands scrambled during run, back-to-back acceptance.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h05;
        sb8.push_back(model(8'h10, 8'h05, 8));
        @(negedge clk);
        n = 0;
        while (!done8 && n < 40) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (!done8) flag_fail("held_start_timeout");
        a8 = 8'h33; b8 = 8'h44;
        sb8.push_back(model(8'h33, 8'h44, 8));
        @(negedge clk);
        check("b2b_idle", 32'(busy8), 32'd0);
        check("b2b_hold", 32'(diff8), 32'h0B);
        @(negedge clk);
        check("b2b_accept", 32'(busy8), 32'd1);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) flag_fail("b2b_timeout");
        @(negedge clk);

        // Asynchronous reset mid-run at count 4.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        check("mid_rst_diff", 32'(diff8), 32'd0);
        check("mid_rst_bout", 32'(bout8), 32'd0);
        check("mid_rst_ovf", 32'(ovf8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        op8(8'hFF, 8'hFF, model(8'hFF, 8'hFF, 8));

        // Random pairs at both widths.
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            op8(a8, b8, model({8'h00, a8}, {8'h00, b8}, 8));
        end
        for (int i = 0; i < 1000; i++) begin
            op16(16'($urandom), 16'($urandom));
        end

        check("sb8_drained", 32'(sb8.size()), 32'd0);
        check("sb16_drained", 32'(sb16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
